// File: rtl/msdf_test_pkg.sv
// Shared definitions for the MSDF arithmetic test sequencer and its HPS-side wrapper.
//   - state_e          : sequencer FSM state encoding
//   - TIMEOUT_SENTINEL : all-ones result written for an abandoned vector (sliced to RES_WIDTH)
//   - REG_OFS_*        : word offsets of the status registers seen by the HPS
package msdf_test_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StLoad   = 3'd2,
        StLaunch = 3'd3,
        StWait   = 3'd4,
        StWrite  = 3'd5,
        StDone   = 3'd6
    } state_e;

    // Widest result bus supported; users slice the sentinel down to their RES_WIDTH.
    localparam int unsigned MAX_RES_WIDTH = 128;
    localparam logic [MAX_RES_WIDTH-1:0] TIMEOUT_SENTINEL = '1;

    // Status register word offsets used by the HPS-side wrapper.
    localparam logic [3:0] REG_OFS_CYCLES   = 4'h0;
    localparam logic [3:0] REG_OFS_TIMEOUTS = 4'h1;
    localparam logic [3:0] REG_OFS_BUSY     = 4'h2;
    localparam logic [3:0] REG_OFS_DONE     = 4'h3;

    function automatic logic is_busy(input state_e s);
        return (s != StIdle) && (s != StDone);
    endfunction

endpackage

// File: rtl/msdf_test_sequencer.sv
// MSDF arithmetic test sequencer (ram_clock domain).
// On an accepted start it walks addresses 0..count-1: fetches an operand pair from the two
// operand RAMs, launches the multiplier with a start/done handshake, and writes the result
// (or the all-ones timeout sentinel) into the result RAM. Reports run status to the HPS.
//
// Ports:
//   ram_clock, reset        : sole clock, synchronous active-high reset
//   start, count            : run request and vector count (0..2^ADDR_WIDTH), sampled in IDLE/DONE
//   busy, done              : run in progress / run complete (level)
//   cycles, timeouts        : busy-cycle count (saturating) and timed-out vectors of the run
//   addr_op, q_x, q_y       : operand RAM address and read data (1-cycle read latency)
//   addr_res, data_res,
//   we_res                  : result RAM write port
//   dut_start, dut_x, dut_y : multiplier launch pulse and registered operands
//   dut_done, dut_result    : multiplier result-valid pulse and result
module msdf_test_sequencer
    import msdf_test_pkg::*;
#(
    parameter int unsigned OP_WIDTH   = 32,
    parameter int unsigned RES_WIDTH  = 64,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                  ram_clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           cycles,
    output logic [ADDR_WIDTH:0]   timeouts,
    output logic [ADDR_WIDTH-1:0] addr_op,
    input  logic [OP_WIDTH-1:0]   q_x,
    input  logic [OP_WIDTH-1:0]   q_y,
    output logic [ADDR_WIDTH-1:0] addr_res,
    output logic [RES_WIDTH-1:0]  data_res,
    output logic                  we_res,
    output logic                  dut_start,
    output logic [OP_WIDTH-1:0]   dut_x,
    output logic [OP_WIDTH-1:0]   dut_y,
    input  logic                  dut_done,
    input  logic [RES_WIDTH-1:0]  dut_result
);

    localparam int unsigned CNT_WIDTH  = ADDR_WIDTH + 1;
    localparam int unsigned WAIT_WIDTH = $clog2(TIMEOUT + 1);
    // Counter value during the last permitted WAIT cycle (counter is 0 in the first one).
    localparam logic [WAIT_WIDTH-1:0] WAIT_LAST = WAIT_WIDTH'(TIMEOUT - 1);
    localparam logic [RES_WIDTH-1:0]  SENTINEL  = TIMEOUT_SENTINEL[RES_WIDTH-1:0];

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [WAIT_WIDTH-1:0] wait_q, wait_d;
    logic [31:0]           cycles_q, cycles_d;
    logic [CNT_WIDTH-1:0]  timeouts_q, timeouts_d;
    logic [ADDR_WIDTH-1:0] addr_op_q, addr_op_d;
    logic [ADDR_WIDTH-1:0] addr_res_q, addr_res_d;
    logic [RES_WIDTH-1:0]  data_res_q, data_res_d;
    logic                  we_res_q, we_res_d;
    logic                  dut_start_q, dut_start_d;
    logic [OP_WIDTH-1:0]   dut_x_q, dut_x_d;
    logic [OP_WIDTH-1:0]   dut_y_q, dut_y_d;

    assign busy     = is_busy(state_q);
    assign done     = (state_q == StDone);
    assign cycles   = cycles_q;
    assign timeouts = timeouts_q;
    assign addr_op  = addr_op_q;
    assign addr_res = addr_res_q;
    assign data_res = data_res_q;
    assign we_res   = we_res_q;
    assign dut_start = dut_start_q;
    assign dut_x    = dut_x_q;
    assign dut_y    = dut_y_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        idx_d       = idx_q;
        wait_d      = wait_q;
        cycles_d    = cycles_q;
        timeouts_d  = timeouts_q;
        addr_op_d   = addr_op_q;
        addr_res_d  = addr_res_q;
        data_res_d  = data_res_q;
        dut_x_d     = dut_x_q;
        dut_y_d     = dut_y_q;
        we_res_d    = 1'b0;
        dut_start_d = 1'b0;

        if (busy && (cycles_q != 32'hFFFF_FFFF)) begin
            cycles_d = cycles_q + 32'd1;
        end

        // Registered outputs are loaded on the transition into the state that owns them,
        // so addr_op/dut_start/we_res are valid during FETCH/LAUNCH/WRITE respectively.
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    count_d    = count;
                    idx_d      = '0;
                    cycles_d   = '0;
                    timeouts_d = '0;
                    addr_op_d  = '0;
                    state_d    = (count == '0) ? StDone : StFetch;
                end
            end
            StFetch: begin
                state_d = StLoad;
            end
            StLoad: begin
                dut_x_d     = q_x;
                dut_y_d     = q_y;
                dut_start_d = 1'b1;
                state_d     = StLaunch;
            end
            StLaunch: begin
                wait_d  = '0;
                state_d = StWait;
            end
            StWait: begin
                wait_d = wait_q + WAIT_WIDTH'(1);
                // A result arriving in the final permitted cycle still counts.
                if (dut_done) begin
                    data_res_d = dut_result;
                    addr_res_d = idx_q;
                    we_res_d   = 1'b1;
                    state_d    = StWrite;
                end else if (wait_q == WAIT_LAST) begin
                    data_res_d = SENTINEL;
                    addr_res_d = idx_q;
                    we_res_d   = 1'b1;
                    timeouts_d = timeouts_q + CNT_WIDTH'(1);
                    state_d    = StWrite;
                end
            end
            StWrite: begin
                // Compare at CNT_WIDTH so count = 2^ADDR_WIDTH terminates without idx wrapping.
                if ({1'b0, idx_q} == (count_q - CNT_WIDTH'(1))) begin
                    state_d = StDone;
                end else begin
                    idx_d     = idx_q + ADDR_WIDTH'(1);
                    addr_op_d = idx_q + ADDR_WIDTH'(1);
                    state_d   = StFetch;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge ram_clock) begin
        if (reset) begin
            state_q     <= StIdle;
            count_q     <= '0;
            idx_q       <= '0;
            wait_q      <= '0;
            cycles_q    <= '0;
            timeouts_q  <= '0;
            addr_op_q   <= '0;
            addr_res_q  <= '0;
            data_res_q  <= '0;
            we_res_q    <= 1'b0;
            dut_start_q <= 1'b0;
            dut_x_q     <= '0;
            dut_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            wait_q      <= wait_d;
            cycles_q    <= cycles_d;
            timeouts_q  <= timeouts_d;
            addr_op_q   <= addr_op_d;
            addr_res_q  <= addr_res_d;
            data_res_q  <= data_res_d;
            we_res_q    <= we_res_d;
            dut_start_q <= dut_start_d;
            dut_x_q     <= dut_x_d;
            dut_y_q     <= dut_y_d;
        end
    end

endmodule

// File: tb/tb_msdf_test_sequencer.sv
// Self-checking bench for msdf_test_sequencer: operand/result RAM models, a multiplier model
// with programmable latency (or silence), and a write scoreboard fed as runs are started.
module tb_msdf_test_sequencer;

    localparam int unsigned OW = 32;
    localparam int unsigned RW = 64;
    localparam int unsigned AW = 11;
    localparam int unsigned TO = 8;

    logic          ram_clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   count = '0;
    logic          busy, done, we_res, dut_start, dut_done;
    logic [31:0]   cycles;
    logic [AW:0]   timeouts;
    logic [AW-1:0] addr_op, addr_res;
    logic [OW-1:0] q_x = '0, q_y = '0, dut_x, dut_y;
    logic [RW-1:0] data_res, dut_result;

    msdf_test_sequencer #(
        .OP_WIDTH  (OW),
        .RES_WIDTH (RW),
        .ADDR_WIDTH(AW),
        .TIMEOUT   (TO)
    ) u_dut (
        .ram_clock (ram_clock),
        .reset     (reset),
        .start     (start),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .cycles    (cycles),
        .timeouts  (timeouts),
        .addr_op   (addr_op),
        .q_x       (q_x),
        .q_y       (q_y),
        .addr_res  (addr_res),
        .data_res  (data_res),
        .we_res    (we_res),
        .dut_start (dut_start),
        .dut_x     (dut_x),
        .dut_y     (dut_y),
        .dut_done  (dut_done),
        .dut_result(dut_result)
    );

    always #5 ram_clock = ~ram_clock;

    // RAM models (only the low 4 address bits are exercised).
    logic [OW-1:0] ram_x [16];
    logic [OW-1:0] ram_y [16];
    logic [RW-1:0] ram_res [16];

    always @(posedge ram_clock) begin
        q_x <= ram_x[addr_op[3:0]];
        q_y <= ram_y[addr_op[3:0]];
        if (we_res) ram_res[addr_res[3:0]] <= data_res;
    end

    // Multiplier model: answers model_lat cycles after the dut_start cycle, except launch
    // number mute_at which never answers. stray_done injects spurious pulses.
    int            model_lat = 5;
    int            mute_at = -1;
    int            model_n = 0;
    int            pend = 0;
    logic [RW-1:0] pend_res = '0;
    logic [RW-1:0] model_res = '0;
    logic          model_done = 1'b0;
    logic          stray_done = 1'b0;
    logic [RW-1:0] prod;

    assign prod       = RW'(dut_x) * RW'(dut_y);
    assign dut_done   = model_done | stray_done;
    assign dut_result = model_res;

    always @(posedge ram_clock) begin
        model_done <= 1'b0;
        if (dut_start) begin
            model_n <= model_n + 1;
            if (model_n != mute_at) begin
                if (model_lat == 1) begin
                    model_done <= 1'b1;
                    model_res  <= prod;
                end else begin
                    pend     <= model_lat - 1;
                    pend_res <= prod;
                end
            end
        end else if (pend != 0) begin
            pend <= pend - 1;
            if (pend == 1) begin
                model_done <= 1'b1;
                model_res  <= pend_res;
            end
        end
    end

    // Scoreboard
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [RW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail = 0;
    int n_writes = 0;
    int n_launches = 0;

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int a, input logic [RW-1:0] d);
        exp_t e;
        e.addr = AW'(a);
        e.data = d;
        exp_q.push_back(e);
    endtask

    always @(negedge ram_clock) begin
        exp_t e;
        if (dut_start) n_launches++;
        if (we_res) begin
            n_writes++;
            n_checks++;
            assert (exp_q.size() != 0)
            else begin
                n_fail++;
                $error("FAIL sb_underflow: observed write addr 0x%0h data 0x%0h expected none",
                       addr_res, data_res);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_addr", RW'(addr_res), RW'(e.addr));
                check("sb_data", data_res, e.data);
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge ram_clock);
        reset = 1'b0;
        @(negedge ram_clock);
    endtask

    task automatic pulse_start(input int n);
        count = (AW+1)'(n);
        start = 1'b1;
        @(negedge ram_clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        for (int i = 0; i < budget && !done; i++) @(negedge ram_clock);
        check(tag, RW'(done), RW'(1));
    endtask

    task automatic wait_launch(input int budget, input string tag);
        for (int i = 0; i < budget && !dut_start; i++) @(negedge ram_clock);
        check(tag, RW'(dut_start), RW'(1));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, RW'(busy), '0);
        check({tag, "_done"}, RW'(done), '0);
        check({tag, "_cycles"}, RW'(cycles), '0);
        check({tag, "_timeouts"}, RW'(timeouts), '0);
        check({tag, "_addr_op"}, RW'(addr_op), '0);
        check({tag, "_addr_res"}, RW'(addr_res), '0);
        check({tag, "_data_res"}, data_res, '0);
        check({tag, "_we_res"}, RW'(we_res), '0);
        check({tag, "_dut_start"}, RW'(dut_start), '0);
        check({tag, "_dut_x"}, RW'(dut_x), '0);
        check({tag, "_dut_y"}, RW'(dut_y), '0);
    endtask

    task automatic load_t1_operands();
        ram_x[0] = 32'd3;          ram_y[0] = 32'd4;
        ram_x[1] = 32'hFFFF_FFFF;  ram_y[1] = 32'd2;
        ram_x[2] = 32'd7;          ram_y[2] = 32'd0;
    endtask

    task automatic push_t1_exp();
        push_exp(0, 64'd12);
        push_exp(1, 64'h1_FFFF_FFFE);
        push_exp(2, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_l;
        int base_w;

        for (int i = 0; i < 16; i++) begin
            ram_x[i] = '0;
            ram_y[i] = '0;
            ram_res[i] = 64'hDEAD;
        end

        // Reset state
        repeat (3) @(negedge ram_clock);
        check_all_zero("rst");
        reset = 1'b0;
        @(negedge ram_clock);

        // Three vectors, L = 5
        load_t1_operands();
        push_t1_exp();
        base_l = n_launches;
        pulse_start(3);
        check("t1_busy_rise", RW'(busy), RW'(1));
        check("t1_done_low", RW'(done), RW'(0));
        wait_done(200, "t1_done");
        check("t1_cycles", RW'(cycles), RW'(27));
        check("t1_timeouts", RW'(timeouts), RW'(0));
        check("t1_busy_low", RW'(busy), RW'(0));
        check("t1_launches", RW'(n_launches - base_l), RW'(3));
        check("t1_ram0", ram_res[0], 64'd12);
        check("t1_ram1", ram_res[1], 64'h1_FFFF_FFFE);
        check("t1_ram2", ram_res[2], 64'd0);
        check("t1_sb_empty", RW'(exp_q.size()), RW'(0));

        // count = 0: immediate DONE, no activity
        do_reset();
        base_l = n_launches;
        base_w = n_writes;
        pulse_start(0);
        check("t2_done", RW'(done), RW'(1));
        check("t2_busy", RW'(busy), RW'(0));
        check("t2_cycles", RW'(cycles), RW'(0));
        repeat (5) @(negedge ram_clock);
        check("t2_no_launch", RW'(n_launches - base_l), RW'(0));
        check("t2_no_write", RW'(n_writes - base_w), RW'(0));

        // Multiplier silent on vector 1 of 2
        ram_x[0] = 32'd5;  ram_y[0] = 32'd6;
        ram_x[1] = 32'd9;  ram_y[1] = 32'd9;
        mute_at = model_n + 1;
        push_exp(0, 64'd30);
        push_exp(1, '1);
        pulse_start(2);
        wait_done(200, "t3_done");
        mute_at = -1;
        check("t3_timeouts", RW'(timeouts), RW'(1));
        check("t3_cycles", RW'(cycles), RW'(21));
        check("t3_ram0", ram_res[0], 64'd30);
        check("t3_ram1", ram_res[1], '1);

        // dut_done coincides with the final permitted WAIT cycle
        model_lat = TO;
        ram_x[0] = 32'd11; ram_y[0] = 32'd13;
        push_exp(0, 64'd143);
        pulse_start(1);
        wait_done(200, "t4_done");
        model_lat = 5;
        check("t4_timeouts", RW'(timeouts), RW'(0));
        check("t4_cycles", RW'(cycles), RW'(12));
        check("t4_ram0", ram_res[0], 64'd143);

        // Stray dut_done in IDLE, then start pulsed during WAIT
        do_reset();
        base_w = n_writes;
        stray_done = 1'b1;
        @(negedge ram_clock);
        stray_done = 1'b0;
        repeat (3) @(negedge ram_clock);
        check("t5_idle_busy", RW'(busy), RW'(0));
        check("t5_idle_no_write", RW'(n_writes - base_w), RW'(0));
        load_t1_operands();
        for (int i = 0; i < 3; i++) ram_res[i] = 64'hDEAD;
        push_t1_exp();
        base_l = n_launches;
        pulse_start(3);
        wait_launch(20, "t5_launch_seen");
        @(negedge ram_clock);
        pulse_start(1);
        wait_done(200, "t5_done");
        check("t5_launches", RW'(n_launches - base_l), RW'(3));
        check("t5_cycles", RW'(cycles), RW'(27));
        check("t5_ram2", ram_res[2], 64'd0);
        check("t5_sb_empty", RW'(exp_q.size()), RW'(0));

        // Reset during WAIT of vector 1
        ram_res[1] = 64'hDEAD;
        push_exp(0, 64'd12);
        base_l = n_launches;
        base_w = n_writes;
        pulse_start(3);
        wait_launch(20, "t6_launch0");
        @(negedge ram_clock);
        wait_launch(20, "t6_launch1");
        @(negedge ram_clock);
        reset = 1'b1;
        @(negedge ram_clock);
        check_all_zero("t6_rst");
        reset = 1'b0;
        repeat (20) @(negedge ram_clock);
        check("t6_writes", RW'(n_writes - base_w), RW'(1));
        check("t6_launches", RW'(n_launches - base_l), RW'(2));
        check("t6_ram1_untouched", ram_res[1], 64'hDEAD);
        check("t6_sb_empty", RW'(exp_q.size()), RW'(0));
        push_t1_exp();
        base_l = n_launches;
        pulse_start(3);
        wait_done(200, "t6_rerun_done");
        check("t6_rerun_launches", RW'(n_launches - base_l), RW'(3));
        check("t6_rerun_cycles", RW'(cycles), RW'(27));
        check("t6_rerun_ram1", ram_res[1], 64'h1_FFFF_FFFE);
        check("t6_rerun_sb_empty", RW'(exp_q.size()), RW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/msdf_test_sequencer.md
# msdf_test_sequencer

Arithmetic-side test sequencer on the `ram_clock` domain. It sits between two operand `dpRam` instances, the multiplier under test and one result `dpRam` instance. On a start pulse it walks addresses 0..count-1: it reads an operand pair from the operand RAMs, launches the multiplier with a start/done handshake, and writes each result (or a timeout sentinel) into the result RAM. It also reports busy/done status, total busy cycles and timeout count for the HPS.

## Interface
Parameters:
- `OP_WIDTH`, 32: operand width; matches the operand `dpRam` DATA_WIDTH.
- `RES_WIDTH`, 64: result width; matches the result `dpRam` DATA_WIDTH.
- `ADDR_WIDTH`, 11: RAM address width.
- `TIMEOUT`, 1024: maximum WAIT cycles per vector before abandoning it (≥2).

Ports:
- `ram_clock`  in  1  sole clock; all RAM arith ports and the DUT run on it.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle run request; sampled only in IDLE or DONE.
- `count`  in  ADDR_WIDTH+1  number of vectors, 0..2^ADDR_WIDTH; sampled with `start`.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  level; high from run completion until next accepted `start` or `reset`.
- `cycles`  out  32  busy-cycle count of the last/current run; saturates at 0xFFFFFFFF.
- `timeouts`  out  ADDR_WIDTH+1  vectors that timed out in the current run.
- `addr_op`  out  ADDR_WIDTH  address to both operand RAMs (`addr_arith`); their `we_arith` is tied 0 externally.
- `q_x`, `q_y`  in  OP_WIDTH  operand RAM `q_arith` outputs; valid 1 cycle after address.
- `addr_res`  out  ADDR_WIDTH  result RAM `addr_arith`.
- `data_res`  out  RES_WIDTH  result RAM `data_arith`.
- `we_res`  out  1  result RAM `we_arith`.
- `dut_start`  out  1  one-cycle launch pulse to the multiplier.
- `dut_x`, `dut_y`  out  OP_WIDTH  registered operands; held stable from LAUNCH until the next LOAD.
- `dut_done`  in  1  result-valid pulse; earliest 1 cycle after `dut_start`.
- `dut_result`  in  RES_WIDTH  sampled in the cycle `dut_done` is high.

## Operation
- States: IDLE, FETCH, LOAD, LAUNCH, WAIT, WRITE, DONE.
- IDLE/DONE + `start`:
  - Latch `count`, clear `idx`, `cycles` and `timeouts`, drop `done`.
  - `count`==0: go to DONE.
  - Otherwise: go to FETCH.
- FETCH: `addr_op`=`idx`. Always go to LOAD.
- LOAD: register `q_x`/`q_y` into `dut_x`/`dut_y`. Go to LAUNCH.
- LAUNCH: `dut_start`=1 for this cycle only; clear the wait counter. Go to WAIT.
- WAIT: increment the wait counter each cycle.
  - `dut_done`=1: capture `dut_result`, go to WRITE.
  - Else, when the wait counter reaches TIMEOUT: capture all-ones, increment `timeouts`, go to WRITE.
  - If `dut_done` and the timeout coincide, `dut_done` wins.
- WRITE: `we_res`=1, `addr_res`=`idx`, `data_res`=captured value.
  - If `idx`==count-1: go to DONE.
  - Else: `idx`+1, go to FETCH.
  - `idx` never wraps: count 2^ADDR_WIDTH ends at `idx` 2^ADDR_WIDTH-1.
- `start` in any state other than IDLE/DONE is ignored. `dut_done` outside WAIT is ignored.
- `busy` = state ∉ {IDLE, DONE}. `cycles` increments in every busy cycle.

## Timing
- Reset values: state IDLE; every output 0 (`busy`, `done`, `cycles`, `timeouts`, `addr_op`, `addr_res`, `data_res`, `we_res`, `dut_start`, `dut_x`, `dut_y`).
- Reset mid-run: abandon at the next edge. No further `we_res`/`dut_start`; partial results stay in RAM.
- `busy` rises the cycle after `start` is sampled.
- Per-vector latency: 4+L cycles, where L = cycles from the `dut_start` cycle to the `dut_done` cycle (L≥1). For a timeout, L is replaced by TIMEOUT.
- Run of N vectors: `cycles` = N·(4+L). `done` rises the cycle after the last WRITE.
- `we_res` and `dut_start` are single-cycle pulses, registered outputs.

## Structure
- Shared package `msdf_test_pkg` holds:
  - state encoding constants;
  - the timeout sentinel (all-ones of RES_WIDTH);
  - the status register offsets the HPS-side wrapper uses for `cycles`, `timeouts`, `busy`, `done`.
- Single module; no sub-module needed. Wait counter, `idx` and `cycles` are local registers.

## Test plan
- Three vectors, DUT model L=5 returning x·y: operands (3,4), (0xFFFFFFFF,2), (7,0) at addresses 0..2, `count`=3 → result RAM holds 12, 0x1FFFFFFFE, 0; `cycles`=27; `timeouts`=0; `done` high.
- `count`=0 → no `dut_start`, no `we_res`; `done` high 1 cycle after `start`; `cycles`=0.
- DUT never answers on vector 1 of 2, `TIMEOUT`=8 → address 1 holds all-ones; `timeouts`=1; vector 0 correct.
- `dut_done` on the same cycle the wait counter hits TIMEOUT → real result written; `timeouts`=0.
- `start` pulsed during WAIT, and `dut_done` pulsed in IDLE → both ignored; run completes normally with one `dut_start` per vector.
- `reset` asserted in WAIT of vector 1 → next cycle all outputs 0; no further `we_res`; a new `start` reruns from address 0.
